// File: rtl/elevator_controller.sv
// elevator_controller: SCAN sequencing FSM for a 4-floor car.
// Latches hall and car calls, times floor travel and door dwell,
// and clears calls as they are served.
module elevator_controller #(
  parameter int unsigned MOVE_CYCLES = 8,
  parameter int unsigned DOOR_CYCLES = 16,
  parameter int unsigned CNT_W       = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] button_up,
  input  logic [2:0] button_down,
  input  logic [3:0] button_in,
  output logic [1:0] position,
  output logic       moving_up,
  output logic       moving_down,
  output logic       door_open,
  output logic [2:0] pending_up,
  output logic [2:0] pending_down,
  output logic [3:0] pending_in
);

  localparam logic [CNT_W-1:0] MOVE_LAST = CNT_W'(MOVE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DOOR_LAST = CNT_W'(DOOR_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_MOVE_UP   = 2'd1,
    ST_MOVE_DOWN = 2'd2,
    ST_DOOR_OPEN = 2'd3
  } state_e;

  // One-hot bit for floor f.
  function automatic logic [3:0] floor_bit(input logic [1:0] f);
    return 4'(4'b0001 << f);
  endfunction

  // Floors strictly above f.
  function automatic logic [3:0] above_mask(input logic [1:0] f);
    return ~(4'(4'b0010 << f) - 4'd1);
  endfunction

  // Floors strictly below f.
  function automatic logic [3:0] below_mask(input logic [1:0] f);
    return 4'(4'b0001 << f) - 4'd1;
  endfunction

  state_e           state_q;
  logic [1:0]       pos_q;
  logic             dir_up_q;
  logic [CNT_W-1:0] timer_q;
  logic             mv_up_q;
  logic             mv_dn_q;
  logic             door_q;
  logic [2:0]       pend_up_q;
  logic [2:0]       pend_dn_q;
  logic [3:0]       pend_in_q;
  logic [2:0]       pend_up_d;
  logic [2:0]       pend_dn_d;
  logic [3:0]       pend_in_d;

  // Per-floor views of the hall calls (floor 3 has no up, floor 0 no down).
  logic [3:0] up_f;
  logic [3:0] dn_f;
  logic [3:0] any_f;
  logic [3:0] btn_up_f;
  logic [3:0] btn_dn_f;
  logic [1:0] pos_up;
  logic [1:0] pos_dn;
  logic       req_here;
  logic       req_above;
  logic       req_below;
  logic       above_up;
  logic       below_dn;
  logic       stop_up;
  logic       stop_dn;
  logic       move_done;
  logic       door_done;
  logic       reopen;
  logic [3:0] clr_in;
  logic [2:0] clr_up;
  logic [2:0] clr_dn;

  // Request summaries at the current floor and at the floor being approached.
  always_comb begin
    up_f      = {1'b0, pend_up_q};
    dn_f      = {pend_dn_q, 1'b0};
    any_f     = pend_in_q | up_f | dn_f;
    btn_up_f  = {1'b0, button_up};
    btn_dn_f  = {button_down, 1'b0};
    pos_up    = pos_q + 2'd1;
    pos_dn    = pos_q - 2'd1;
    req_here  = any_f[pos_q];
    req_above = |(any_f & above_mask(pos_q));
    req_below = |(any_f & below_mask(pos_q));
    above_up  = |(any_f & above_mask(pos_up));
    below_dn  = |(any_f & below_mask(pos_dn));
    stop_up   = pend_in_q[pos_up] | up_f[pos_up] | ~above_up;
    stop_dn   = pend_in_q[pos_dn] | dn_f[pos_dn] | ~below_dn;
    move_done = (timer_q == MOVE_LAST);
    door_done = (timer_q == DOOR_LAST);
    reopen    = button_in[pos_q] | (dir_up_q ? btn_up_f[pos_q] : btn_dn_f[pos_q]);
  end

  // Call clearing for served floors; a clear wins over a same-cycle press.
  always_comb begin
    clr_in = '0;
    clr_up = '0;
    clr_dn = '0;
    case (state_q)
      ST_IDLE: begin
        if (req_here) begin
          clr_in = floor_bit(pos_q);
          clr_up = 3'(floor_bit(pos_q));
          clr_dn = 3'(floor_bit(pos_q) >> 1);
        end
      end
      ST_MOVE_UP: begin
        if (move_done && stop_up) begin
          clr_in = floor_bit(pos_up);
          clr_up = 3'(floor_bit(pos_up));
          if (!above_up) clr_dn = 3'(floor_bit(pos_up) >> 1);
        end
      end
      ST_MOVE_DOWN: begin
        if (move_done && stop_dn) begin
          clr_in = floor_bit(pos_dn);
          clr_dn = 3'(floor_bit(pos_dn) >> 1);
          if (!below_dn) clr_up = 3'(floor_bit(pos_dn));
        end
      end
      ST_DOOR_OPEN: begin
        clr_in = floor_bit(pos_q);
        if (dir_up_q) clr_up = 3'(floor_bit(pos_q));
        else          clr_dn = 3'(floor_bit(pos_q) >> 1);
      end
      default: begin
        clr_in = '0;
      end
    endcase
    pend_in_d = (pend_in_q | button_in)   & ~clr_in;
    pend_up_d = (pend_up_q | button_up)   & ~clr_up;
    pend_dn_d = (pend_dn_q | button_down) & ~clr_dn;
  end

  // Car sequencing FSM with call latches and registered status decodes.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      pos_q     <= '0;
      dir_up_q  <= 1'b1;
      timer_q   <= '0;
      mv_up_q   <= 1'b0;
      mv_dn_q   <= 1'b0;
      door_q    <= 1'b0;
      pend_up_q <= '0;
      pend_dn_q <= '0;
      pend_in_q <= '0;
    end else begin
      pend_up_q <= pend_up_d;
      pend_dn_q <= pend_dn_d;
      pend_in_q <= pend_in_d;
      case (state_q)
        ST_IDLE: begin
          timer_q <= '0;
          if (req_here) begin
            state_q <= ST_DOOR_OPEN;
            door_q  <= 1'b1;
          end else if (req_above && (dir_up_q || !req_below)) begin
            dir_up_q <= 1'b1;
            state_q  <= ST_MOVE_UP;
            mv_up_q  <= 1'b1;
          end else if (req_below) begin
            dir_up_q <= 1'b0;
            state_q  <= ST_MOVE_DOWN;
            mv_dn_q  <= 1'b1;
          end
        end
        ST_MOVE_UP: begin
          if (move_done) begin
            timer_q <= '0;
            pos_q   <= pos_up;
            if (stop_up) begin
              state_q <= ST_DOOR_OPEN;
              mv_up_q <= 1'b0;
              door_q  <= 1'b1;
              if (!above_up) dir_up_q <= 1'b0;
            end
          end else begin
            timer_q <= timer_q + CNT_W'(1);
          end
        end
        ST_MOVE_DOWN: begin
          if (move_done) begin
            timer_q <= '0;
            pos_q   <= pos_dn;
            if (stop_dn) begin
              state_q <= ST_DOOR_OPEN;
              mv_dn_q <= 1'b0;
              door_q  <= 1'b1;
              if (!below_dn) dir_up_q <= 1'b1;
            end
          end else begin
            timer_q <= timer_q + CNT_W'(1);
          end
        end
        ST_DOOR_OPEN: begin
          if (reopen) begin
            timer_q <= '0;
          end else if (door_done) begin
            timer_q <= '0;
            state_q <= ST_IDLE;
            door_q  <= 1'b0;
          end else begin
            timer_q <= timer_q + CNT_W'(1);
          end
        end
        default: begin
          state_q <= ST_IDLE;
          timer_q <= '0;
          mv_up_q <= 1'b0;
          mv_dn_q <= 1'b0;
          door_q  <= 1'b0;
        end
      endcase
    end
  end

  assign position     = pos_q;
  assign moving_up    = mv_up_q;
  assign moving_down  = mv_dn_q;
  assign door_open    = door_q;
  assign pending_up   = pend_up_q;
  assign pending_down = pend_dn_q;
  assign pending_in   = pend_in_q;

endmodule

// File: tb/tb_elevator_controller.sv
// tb_elevator_controller: directed and randomized checks of the elevator
// controller against a per-floor request-list model of the car.
module tb_elevator_controller;

  localparam int MOVE_CYCLES = 4;
  localparam int DOOR_CYCLES = 3;
  localparam int M_IDLE = 0;
  localparam int M_UP   = 1;
  localparam int M_DOWN = 2;
  localparam int M_DOOR = 3;

  logic        clk;
  logic        reset;
  logic [2:0]  button_up;
  logic [2:0]  button_down;
  logic [3:0]  button_in;
  logic [1:0]  position;
  logic        moving_up;
  logic        moving_down;
  logic        door_open;
  logic [2:0]  pending_up;
  logic [2:0]  pending_down;
  logic [3:0]  pending_in;
  logic [14:0] dut_obs;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: car mode, floor, heading, elapsed cycles and call lists per floor.
  int m_mode;
  int m_floor;
  int m_cnt;
  bit m_goup;
  bit m_in[4];
  bit m_hu[4];
  bit m_hd[4];

  elevator_controller #(
    .MOVE_CYCLES(MOVE_CYCLES),
    .DOOR_CYCLES(DOOR_CYCLES),
    .CNT_W(8)
  ) dut (
    .clk(clk),
    .reset(reset),
    .button_up(button_up),
    .button_down(button_down),
    .button_in(button_in),
    .position(position),
    .moving_up(moving_up),
    .moving_down(moving_down),
    .door_open(door_open),
    .pending_up(pending_up),
    .pending_down(pending_down),
    .pending_in(pending_in)
  );

  assign dut_obs = {position, moving_up, moving_down, door_open,
                    pending_up, pending_down, pending_in};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit any_at(input int f);
    return m_in[f] || m_hu[f] || m_hd[f];
  endfunction

  function automatic bit any_above(input int f);
    bit r = 0;
    for (int g = f + 1; g < 4; g++) if (any_at(g)) r = 1;
    return r;
  endfunction

  function automatic bit any_below(input int f);
    bit r = 0;
    for (int g = 0; g < f; g++) if (any_at(g)) r = 1;
    return r;
  endfunction

  // Advance the model by one clock given the inputs sampled at that edge.
  task automatic model_step(input logic rst, input logic [2:0] bu,
                            input logic [2:0] bd, input logic [3:0] bi);
    bit n_in[4];
    bit n_hu[4];
    bit n_hd[4];
    bit hu[4];
    bit hd[4];
    int q;
    if (rst) begin
      m_mode = M_IDLE; m_floor = 0; m_goup = 1; m_cnt = 0;
      for (int f = 0; f < 4; f++) begin m_in[f] = 0; m_hu[f] = 0; m_hd[f] = 0; end
    end else begin
      for (int f = 0; f < 4; f++) begin
        hu[f] = 0;
        hd[f] = 0;
        if (f < 3) hu[f] = bu[f];
        if (f > 0) hd[f] = bd[f-1];
        n_in[f] = m_in[f] || bi[f];
        n_hu[f] = m_hu[f] || hu[f];
        n_hd[f] = m_hd[f] || hd[f];
      end
      case (m_mode)
        M_IDLE: begin
          m_cnt = 0;
          if (any_at(m_floor)) begin
            n_in[m_floor] = 0; n_hu[m_floor] = 0; n_hd[m_floor] = 0;
            m_mode = M_DOOR;
          end else if (any_above(m_floor) && (m_goup || !any_below(m_floor))) begin
            m_goup = 1; m_mode = M_UP;
          end else if (any_below(m_floor)) begin
            m_goup = 0; m_mode = M_DOWN;
          end
        end
        M_UP: begin
          if (m_cnt == MOVE_CYCLES - 1) begin
            q = m_floor + 1;
            m_cnt = 0;
            if (m_in[q] || m_hu[q] || !any_above(q)) begin
              n_in[q] = 0; n_hu[q] = 0;
              if (!any_above(q)) begin n_hd[q] = 0; m_goup = 0; end
              m_mode = M_DOOR;
            end
            m_floor = q;
          end else m_cnt++;
        end
        M_DOWN: begin
          if (m_cnt == MOVE_CYCLES - 1) begin
            q = m_floor - 1;
            m_cnt = 0;
            if (m_in[q] || m_hd[q] || !any_below(q)) begin
              n_in[q] = 0; n_hd[q] = 0;
              if (!any_below(q)) begin n_hu[q] = 0; m_goup = 1; end
              m_mode = M_DOOR;
            end
            m_floor = q;
          end else m_cnt++;
        end
        default: begin
          n_in[m_floor] = 0;
          if (m_goup) n_hu[m_floor] = 0;
          else        n_hd[m_floor] = 0;
          if (bi[m_floor] || (m_goup ? hu[m_floor] : hd[m_floor])) m_cnt = 0;
          else if (m_cnt == DOOR_CYCLES - 1) begin m_mode = M_IDLE; m_cnt = 0; end
          else m_cnt++;
        end
      endcase
      for (int f = 0; f < 4; f++) begin
        m_in[f] = n_in[f]; m_hu[f] = n_hu[f]; m_hd[f] = n_hd[f];
      end
    end
  endtask

  function automatic logic [14:0] model_obs();
    logic [2:0] pu;
    logic [2:0] pd;
    logic [3:0] pi;
    for (int f = 0; f < 3; f++) begin pu[f] = m_hu[f]; pd[f] = m_hd[f+1]; end
    for (int f = 0; f < 4; f++) pi[f] = m_in[f];
    return {2'(m_floor), m_mode == M_UP, m_mode == M_DOWN, m_mode == M_DOOR, pu, pd, pi};
  endfunction

  // Drive inputs on the falling edge, take the rising edge, then settle.
  task automatic step(input logic rst, input logic [2:0] bu,
                      input logic [2:0] bd, input logic [3:0] bi);
    @(negedge clk);
    reset = rst; button_up = bu; button_down = bd; button_in = bi;
    @(posedge clk);
    model_step(rst, bu, bd, bi);
    #1;
  endtask

  task automatic test_reset();
    logic [14:0] exp;
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 3'b111, 3'b111, 4'b1111);
      exp = model_obs();
      vectors++;
      if (dut_obs !== exp) begin
        $display("FAIL reset_model cycle %0d: got %h expected %h", i, dut_obs, exp);
        miscompares++;
      end
    end
    vectors++;
    if (dut_obs !== 15'd0) begin
      $display("FAIL reset_state: got %h expected %h", dut_obs, 15'd0);
      miscompares++;
    end
    step(1'b0, 3'b000, 3'b000, 4'b0000);
    vectors++;
    if (dut_obs !== 15'd0) begin
      $display("FAIL reset_release: got %h expected %h", dut_obs, 15'd0);
      miscompares++;
    end
  endtask

  task automatic test_hall_here();
    logic [14:0] exp;
    for (int k = 1; k <= 6; k++) begin
      step(1'b0, (k == 1) ? 3'b001 : 3'b000, 3'b000, 4'b0000);
      exp = model_obs();
      vectors++;
      if (dut_obs !== exp) begin
        $display("FAIL hall_here_model k=%0d: got %h expected %h", k, dut_obs, exp);
        miscompares++;
      end
      vectors++;
      if (k == 1 && (pending_up !== 3'b001 || door_open !== 1'b0)) begin
        $display("FAIL hall_here_latch: got up=%b door=%b expected up=001 door=0", pending_up, door_open);
        miscompares++;
      end else if (k >= 2 && (pending_up[0] !== 1'b0 || door_open !== (k <= 4)
                 || moving_up !== 1'b0 || moving_down !== 1'b0 || position !== 2'd0)) begin
        $display("FAIL hall_here_door k=%0d: got up0=%b door=%b mu=%b md=%b pos=%0d expected up0=0 door=%0d no motion pos=0",
                 k, pending_up[0], door_open, moving_up, moving_down, position, (k <= 4));
        miscompares++;
      end
    end
  endtask

  task automatic test_single_call();
    logic [14:0] exp;
    for (int k = 1; k <= 14; k++) begin
      step(1'b0, 3'b000, 3'b000, (k == 1) ? 4'b0100 : 4'b0000);
      exp = model_obs();
      vectors++;
      if (dut_obs !== exp) begin
        $display("FAIL single_call_model k=%0d: got %h expected %h", k, dut_obs, exp);
        miscompares++;
      end
      case (k)
        1: begin
          vectors++;
          if (pending_in !== 4'b0100 || moving_up !== 1'b0) begin
            $display("FAIL single_call_latch: got in=%b mu=%b expected in=0100 mu=0", pending_in, moving_up);
            miscompares++;
          end
        end
        2, 5: begin
          vectors++;
          if (moving_up !== 1'b1 || position !== 2'd0) begin
            $display("FAIL single_call_depart k=%0d: got mu=%b pos=%0d expected mu=1 pos=0", k, moving_up, position);
            miscompares++;
          end
        end
        6: begin
          vectors++;
          if (moving_up !== 1'b1 || position !== 2'd1) begin
            $display("FAIL single_call_floor1: got mu=%b pos=%0d expected mu=1 pos=1", moving_up, position);
            miscompares++;
          end
        end
        10: begin
          vectors++;
          if (position !== 2'd2 || door_open !== 1'b1 || moving_up !== 1'b0 || pending_in !== 4'b0000) begin
            $display("FAIL single_call_arrive: got pos=%0d door=%b mu=%b in=%b expected pos=2 door=1 mu=0 in=0000",
                     position, door_open, moving_up, pending_in);
            miscompares++;
          end
        end
        12: begin
          vectors++;
          if (door_open !== 1'b1) begin
            $display("FAIL single_call_dwell: got door=%b expected 1", door_open);
            miscompares++;
          end
        end
        13: begin
          vectors++;
          if (door_open !== 1'b0 || moving_up !== 1'b0 || moving_down !== 1'b0 || position !== 2'd2) begin
            $display("FAIL single_call_idle: got door=%b mu=%b md=%b pos=%0d expected idle at 2",
                     door_open, moving_up, moving_down, position);
            miscompares++;
          end
        end
        default: ;
      endcase
    end
  endtask

  task automatic test_scan();
    logic [14:0] exp;
    int stops[$];
    bit prev_door;
    bit done;
    step(1'b1, 3'b000, 3'b000, 4'b0000);
    prev_door = 0;
    done = 0;
    for (int k = 1; k <= 150 && !done; k++) begin
      step(1'b0, 3'b000, (k == 4) ? 3'b001 : 3'b000, (k == 1) ? 4'b1000 : 4'b0000);
      exp = model_obs();
      vectors++;
      if (dut_obs !== exp) begin
        $display("FAIL scan_model k=%0d: got %h expected %h", k, dut_obs, exp);
        miscompares++;
      end
      if (door_open === 1'b1 && !prev_door) stops.push_back(int'(position));
      prev_door = (door_open === 1'b1);
      if (stops.size() >= 2 && !door_open && !moving_up && !moving_down) done = 1;
    end
    vectors++;
    if (!done || stops.size() != 2) begin
      $display("FAIL scan_budget: got %0d stops done=%0d expected 2 stops then idle", stops.size(), done);
      miscompares++;
    end else if (stops[0] != 3 || stops[1] != 1) begin
      $display("FAIL scan_order: got stops %0d,%0d expected 3,1", stops[0], stops[1]);
      miscompares++;
    end
    vectors++;
    if (position !== 2'd1 || pending_down !== 3'b000 || pending_in !== 4'b0000 || pending_up !== 3'b000) begin
      $display("FAIL scan_final: got pos=%0d dn=%b in=%b up=%b expected pos=1 all pending 0",
               position, pending_down, pending_in, pending_up);
      miscompares++;
    end
  endtask

  task automatic test_door_reopen();
    logic [14:0] exp;
    bit opened = 0;
    for (int k = 1; k <= 40 && !opened; k++) begin
      step(1'b0, 3'b000, 3'b000, (k == 1) ? 4'b0100 : 4'b0000);
      exp = model_obs();
      vectors++;
      if (dut_obs !== exp) begin
        $display("FAIL reopen_travel k=%0d: got %h expected %h", k, dut_obs, exp);
        miscompares++;
      end
      if (door_open === 1'b1) opened = 1;
    end
    vectors++;
    if (!opened || position !== 2'd2) begin
      $display("FAIL reopen_arrive: got opened=%0d pos=%0d expected door open at 2", opened, position);
      miscompares++;
    end
    for (int j = 1; j <= 6; j++) begin
      step(1'b0, 3'b000, 3'b000, (j == 3) ? 4'b0100 : 4'b0000);
      exp = model_obs();
      vectors++;
      if (dut_obs !== exp) begin
        $display("FAIL reopen_model j=%0d: got %h expected %h", j, dut_obs, exp);
        miscompares++;
      end
      vectors++;
      if (door_open !== (j <= 5) || pending_in[2] !== 1'b0) begin
        $display("FAIL reopen_dwell j=%0d: got door=%b in2=%b expected door=%0d in2=0",
                 j, door_open, pending_in[2], (j <= 5));
        miscompares++;
      end
    end
  endtask

  task automatic test_reset_mid_move();
    logic [14:0] exp;
    bit reached = 0;
    step(1'b1, 3'b000, 3'b000, 4'b0000);
    for (int k = 1; k <= 30 && !reached; k++) begin
      step(1'b0, 3'b000, 3'b000, (k == 1) ? 4'b1000 : 4'b0000);
      exp = model_obs();
      vectors++;
      if (dut_obs !== exp) begin
        $display("FAIL midreset_travel k=%0d: got %h expected %h", k, dut_obs, exp);
        miscompares++;
      end
      if (position === 2'd1 && moving_up === 1'b1) reached = 1;
    end
    step(1'b0, 3'b000, 3'b000, 4'b0000);
    step(1'b0, 3'b000, 3'b000, 4'b0000);
    vectors++;
    if (!reached || moving_up !== 1'b1 || pending_in[3] !== 1'b1) begin
      $display("FAIL midreset_setup: got reached=%0d mu=%b in3=%b expected moving up with in3=1",
               reached, moving_up, pending_in[3]);
      miscompares++;
    end
    step(1'b1, 3'b000, 3'b000, 4'b0000);
    vectors++;
    if (dut_obs !== 15'd0) begin
      $display("FAIL midreset_abort: got %h expected %h", dut_obs, 15'd0);
      miscompares++;
    end
    for (int j = 0; j < 5; j++) begin
      step(1'b0, 3'b000, 3'b000, 4'b0000);
      vectors++;
      if (dut_obs !== 15'd0) begin
        $display("FAIL midreset_still j=%0d: got %h expected %h", j, dut_obs, 15'd0);
        miscompares++;
      end
    end
  endtask

  // Random traffic; odds sets how rarely each button bit is pressed.
  task automatic test_random(input string name, input int odds, input int cycles);
    logic [14:0] exp;
    logic [2:0]  bu;
    logic [2:0]  bd;
    logic [3:0]  bi;
    logic        rst;
    for (int n = 0; n < cycles; n++) begin
      bu = '0; bd = '0; bi = '0;
      for (int i = 0; i < 3; i++) begin
        if ($urandom_range(0, odds) == 0) bu[i] = 1'b1;
        if ($urandom_range(0, odds) == 0) bd[i] = 1'b1;
      end
      for (int i = 0; i < 4; i++) if ($urandom_range(0, odds) == 0) bi[i] = 1'b1;
      rst = ($urandom_range(0, 299) == 0);
      step(rst, bu, bd, bi);
      exp = model_obs();
      vectors++;
      if (dut_obs !== exp) begin
        $display("FAIL %s cycle %0d: got %h expected %h", name, n, dut_obs, exp);
        miscompares++;
      end
    end
  endtask

  initial begin
    reset = 1'b1; button_up = '0; button_down = '0; button_in = '0;
    test_reset();
    test_hall_here();
    test_single_call();
    test_scan();
    test_door_reopen();
    test_reset_mid_move();
    test_random("random_sparse", 25, 2500);
    test_random("back_to_back", 3, 600);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
